// File: rtl/vga_timing_receiver_if.sv
// Sync inputs and regenerated timing outputs of the VGA timing receiver.
// Err_Count_Sig is present only when VGA_RX_ERRCNT_EN is defined.
interface vga_timing_receiver_if;
    localparam int unsigned CW = 11;
    localparam int unsigned EW = 8;

    logic          Pixel_En;
    logic          HSYNC_Sig;
    logic          VSYNC_Sig;
    logic          Ready_Sig;
    logic [CW-1:0] Column_Addr_Sig;
    logic [CW-1:0] Row_Addr_Sig;
    logic          Locked_Sig;
    logic [CW-1:0] H_Total_Sig;
    logic [CW-1:0] V_Total_Sig;
    logic          Frame_Start_Sig;
`ifdef VGA_RX_ERRCNT_EN
    logic [EW-1:0] Err_Count_Sig;
`endif

    // Source side: drives syncs, observes the receiver.
    modport master (
`ifdef VGA_RX_ERRCNT_EN
        input  Err_Count_Sig,
`endif
        output Pixel_En, HSYNC_Sig, VSYNC_Sig,
        input  Ready_Sig, Column_Addr_Sig, Row_Addr_Sig, Locked_Sig,
        input  H_Total_Sig, V_Total_Sig, Frame_Start_Sig
    );

    modport slave (
`ifdef VGA_RX_ERRCNT_EN
        output Err_Count_Sig,
`endif
        input  Pixel_En, HSYNC_Sig, VSYNC_Sig,
        output Ready_Sig, Column_Addr_Sig, Row_Addr_Sig, Locked_Sig,
        output H_Total_Sig, V_Total_Sig, Frame_Start_Sig
    );
endinterface

// File: rtl/vga_timing_receiver.sv
// Measures incoming HSYNC/VSYNC timing, locks onto a stable raster and regenerates
// active-video column/row addresses. Define VGA_RX_ERRCNT_EN for the lock-loss counter.
module vga_timing_receiver #(
    parameter int unsigned H_START     = 144,
    parameter int unsigned H_ACTIVE    = 640,
    parameter int unsigned V_START     = 35,
    parameter int unsigned V_ACTIVE    = 480,
    parameter int unsigned LOCK_FRAMES = 2
) (
    input  logic                  CLK,
    input  logic                  RST,
    vga_timing_receiver_if.slave  bus
);
    localparam int unsigned CW = 11;
    localparam int unsigned MW = 3;
    localparam int unsigned EW = 8;
    localparam logic [CW-1:0] CNT_MAX = '1;
    localparam logic [CW-1:0] H_LO    = CW'(H_START);
    localparam logic [CW-1:0] H_HI    = CW'(H_START + H_ACTIVE);
    localparam logic [CW-1:0] V_LO    = CW'(V_START);
    localparam logic [CW-1:0] V_HI    = CW'(V_START + V_ACTIVE);
    localparam logic [MW-1:0] LOCK_N  = MW'(LOCK_FRAMES);

    typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_e;

    state_e        state_q;
    logic          hs_q, vs_line_q, fs_q, ref_valid_q;
    logic [CW-1:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
    logic [CW-1:0] h_tot_q, v_tot_q, ref_h_q, ref_v_q;
    logic [MW-1:0] match_q;
    logic [CW-1:0] h_len, v_len;
    logic          hs_fall, vs_fall, lost_sync, drop, active;

    assign hs_fall   = bus.Pixel_En & hs_q & ~bus.HSYNC_Sig;
    assign vs_fall   = hs_fall & vs_line_q & ~bus.VSYNC_Sig;
    assign h_len     = h_cnt_q + CW'(1);
    assign v_len     = v_cnt_q + CW'(1);
    assign lost_sync = (h_cnt_q == CNT_MAX) | (v_cnt_q == CNT_MAX);
    assign drop      = (state_q == LOCKED) &
                       (lost_sync | (hs_fall & (h_len != ref_h_q)) | (vs_fall & (v_len != ref_v_q)));

    // Pixel/line counters, saturating so a dead sync is detectable.
    always_comb begin
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (hs_fall) begin
            h_cnt_d = '0;
            if (vs_fall)
                v_cnt_d = '0;
            else if (v_cnt_q != CNT_MAX)
                v_cnt_d = v_len;
        end else if (bus.Pixel_En && (h_cnt_q != CNT_MAX)) begin
            h_cnt_d = h_len;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            hs_q      <= 1'b0;
            vs_line_q <= 1'b0;
            fs_q      <= 1'b0;
            h_cnt_q   <= '0;
            v_cnt_q   <= '0;
            h_tot_q   <= '0;
            v_tot_q   <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
            fs_q    <= vs_fall;
            if (bus.Pixel_En) hs_q <= bus.HSYNC_Sig;
            if (hs_fall) begin
                h_tot_q   <= h_len;
                vs_line_q <= bus.VSYNC_Sig;
            end
            if (vs_fall) v_tot_q <= v_len;
        end
    end

    // Lock FSM: a reference frame plus LOCK_FRAMES identical frames are needed to lock.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= SEARCH;
            ref_h_q     <= '0;
            ref_v_q     <= '0;
            ref_valid_q <= 1'b0;
            match_q     <= '0;
        end else if (lost_sync || drop) begin
            state_q     <= SEARCH;
            ref_valid_q <= 1'b0;
            match_q     <= '0;
        end else begin
            unique case (state_q)
                SEARCH: begin
                    ref_valid_q <= 1'b0;
                    match_q     <= '0;
                    if (vs_fall) state_q <= MEASURE;
                end
                MEASURE: begin
                    if (vs_fall) begin
                        if (ref_valid_q && (h_len == ref_h_q) && (v_len == ref_v_q)) begin
                            match_q <= MW'(match_q + MW'(1));
                            if (MW'(match_q + MW'(1)) == LOCK_N) state_q <= LOCKED;
                        end else begin
                            ref_h_q     <= h_len;
                            ref_v_q     <= v_len;
                            ref_valid_q <= 1'b1;
                            match_q     <= '0;
                        end
                    end
                end
                LOCKED:  state_q <= LOCKED;
                default: state_q <= SEARCH;
            endcase
        end
    end

    assign active = (state_q == LOCKED) &
                    (h_cnt_q >= H_LO) & (h_cnt_q < H_HI) &
                    (v_cnt_q >= V_LO) & (v_cnt_q < V_HI);

    assign bus.Ready_Sig       = active;
    assign bus.Column_Addr_Sig = active ? CW'(h_cnt_q - H_LO) : '0;
    assign bus.Row_Addr_Sig    = active ? CW'(v_cnt_q - V_LO) : '0;
    assign bus.Locked_Sig      = (state_q == LOCKED);
    assign bus.H_Total_Sig     = h_tot_q;
    assign bus.V_Total_Sig     = v_tot_q;
    assign bus.Frame_Start_Sig = fs_q;

`ifdef VGA_RX_ERRCNT_EN
    logic [EW-1:0] err_q;

    // Counts lock losses; only RST clears it.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            err_q <= '0;
        else if (drop && (err_q != '1))
            err_q <= EW'(err_q + EW'(1));
    end

    assign bus.Err_Count_Sig = err_q;
`endif
endmodule

// File: tb/tb_vga_timing_receiver.sv
// Randomised-strobe bench for vga_timing_receiver on a compact 40x20 raster,
// checked every cycle against an event-level model of the receiver.
module tb_vga_timing_receiver;
    localparam int H_START  = 8;
    localparam int H_ACTIVE = 24;
    localparam int V_START  = 3;
    localparam int V_ACTIVE = 14;
    localparam int LOCKN    = 2;
    localparam int H_TOT    = 40;
    localparam int V_TOT    = 20;
    localparam int HS_W     = 4;
    localparam int VS_W     = 2;
    localparam int SAT      = 2047;

    bit clk;
    bit rst;
    int n_cmp = 0;
    int n_bad = 0;
    bit pin_win = 0;

    vga_timing_receiver_if bus();

    vga_timing_receiver #(
        .H_START(H_START), .H_ACTIVE(H_ACTIVE), .V_START(V_START),
        .V_ACTIVE(V_ACTIVE), .LOCK_FRAMES(LOCKN)
    ) dut (
        .CLK(clk),
        .RST(rst),
        .bus(bus)
    );

    initial forever #5 clk = ~clk;

    // Model: pixels/lines elapsed since the last detected sync edges, and the
    // list of consecutive identical frame measurements since the last arming.
    int unsigned m_px, m_ln;
    bit m_prev_hs, m_line_vs, m_fs, m_locked, m_armed;
    int m_htot, m_vtot, m_err;
    int hist_h[$];
    int hist_v[$];

    function automatic int sat(input int unsigned x);
        return (x > SAT) ? SAT : int'(x);
    endfunction

    task automatic model_reset();
        m_px = 0; m_ln = 0; m_prev_hs = 0; m_line_vs = 0; m_fs = 0;
        m_locked = 0; m_armed = 0; m_htot = 0; m_vtot = 0; m_err = 0;
        hist_h.delete(); hist_v.delete();
    endtask

    task automatic model_step();
        bit hf, vf, lost, was_locked;
        int h_len, v_len;
        lost  = (m_px >= SAT) || (m_ln >= SAT);
        h_len = (sat(m_px) + 1) % 2048;
        v_len = (sat(m_ln) + 1) % 2048;
        hf = 0; vf = 0;
        if (bus.Pixel_En) begin
            hf = m_prev_hs && !bus.HSYNC_Sig;
            vf = hf && m_line_vs && !bus.VSYNC_Sig;
            m_prev_hs = bus.HSYNC_Sig;
        end
        m_fs = vf;
        if (hf) begin
            m_htot = h_len; m_px = 0; m_line_vs = bus.VSYNC_Sig;
            if (vf) begin m_vtot = v_len; m_ln = 0; end
            else if (m_ln < 4000) m_ln++;
        end else if (bus.Pixel_En && m_px < 4000) begin
            m_px++;
        end
        was_locked = m_locked;
        if (lost) begin
            m_locked = 0; m_armed = 0; hist_h.delete(); hist_v.delete();
        end else if (m_locked) begin
            if ((hf && h_len != hist_h[0]) || (vf && v_len != hist_v[0])) begin
                m_locked = 0; m_armed = 0; hist_h.delete(); hist_v.delete();
            end
        end else if (m_armed) begin
            if (vf) begin
                if (hist_h.size() > 0 && (h_len != hist_h[$] || v_len != hist_v[$])) begin
                    hist_h.delete(); hist_v.delete();
                end
                hist_h.push_back(h_len); hist_v.push_back(v_len);
                if (hist_h.size() == LOCKN + 1) m_locked = 1;
            end
        end else if (vf) begin
            m_armed = 1;
        end
        if (was_locked && !m_locked && m_err < 255) m_err++;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) model_reset(); else model_step();
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        int h, v;
        bit win;
        h = sat(m_px);
        v = sat(m_ln);
        win = m_locked && h >= H_START && h < H_START + H_ACTIVE &&
              v >= V_START && v < V_START + V_ACTIVE;
        chk("ready", 32'(bus.Ready_Sig), 32'(win));
        chk("column", 32'(bus.Column_Addr_Sig), win ? 32'(h - H_START) : 32'd0);
        chk("row", 32'(bus.Row_Addr_Sig), win ? 32'(v - V_START) : 32'd0);
        chk("locked", 32'(bus.Locked_Sig), 32'(m_locked));
        chk("h_total", 32'(bus.H_Total_Sig), 32'(m_htot));
        chk("v_total", 32'(bus.V_Total_Sig), 32'(m_vtot));
        chk("frame_start", 32'(bus.Frame_Start_Sig), 32'(m_fs));
`ifdef VGA_RX_ERRCNT_EN
        chk("err_count", 32'(bus.Err_Count_Sig), 32'(m_err));
`endif
    endtask

    initial forever begin
        @(posedge clk);
        #2;
        compare_all();
    end

    task automatic send_px(input logic hs, input logic vs);
        int gap = $urandom_range(0, 2);
        repeat (gap) begin
            @(negedge clk);
            bus.Pixel_En = 1'b0;
        end
        @(negedge clk);
        bus.Pixel_En = 1'b1; bus.HSYNC_Sig = hs; bus.VSYNC_Sig = vs;
        @(posedge clk);
        #3;
    endtask

    task automatic pin_window(input int ln, input int p);
        if (ln == 2 && p == 20) chk("win_row2_ready", 32'(bus.Ready_Sig), 0);
        if (ln == 3 && p == 7)  chk("win_h7_ready", 32'(bus.Ready_Sig), 0);
        if (ln == 3 && p == 8) begin
            chk("win_first_ready", 32'(bus.Ready_Sig), 1);
            chk("win_first_col", 32'(bus.Column_Addr_Sig), 0);
            chk("win_first_row", 32'(bus.Row_Addr_Sig), 0);
        end
        if (ln == 16 && p == 31) begin
            chk("win_last_ready", 32'(bus.Ready_Sig), 1);
            chk("win_last_col", 32'(bus.Column_Addr_Sig), 23);
            chk("win_last_row", 32'(bus.Row_Addr_Sig), 13);
        end
        if (ln == 16 && p == 32) begin
            chk("win_h32_ready", 32'(bus.Ready_Sig), 0);
            chk("win_h32_col", 32'(bus.Column_Addr_Sig), 0);
        end
        if (ln == 17 && p == 8) chk("win_row17_ready", 32'(bus.Ready_Sig), 0);
    endtask

    task automatic send_line(input int ln, input int p_from, input int p_to);
        for (int p = p_from; p < p_to; p++) begin
            send_px((p < HS_W) ? 1'b0 : 1'b1, (ln < VS_W) ? 1'b0 : 1'b1);
            if (pin_win) pin_window(ln, p);
        end
    endtask

    task automatic send_frame();
        for (int ln = 0; ln < V_TOT; ln++) send_line(ln, 0, H_TOT);
    endtask

    // From a fresh stream start the 4th VSYNC fall opens frame index 4.
    task automatic lock_sequence(input bit pin);
        repeat (4) send_frame();
        chk("locked_before_4th_vs", 32'(bus.Locked_Sig), 0);
        send_line(0, 0, 1);
        chk("locked_after_4th_vs", 32'(bus.Locked_Sig), 1);
        chk("lock_h_total", 32'(bus.H_Total_Sig), H_TOT);
        chk("lock_v_total", 32'(bus.V_Total_Sig), V_TOT);
        chk("lock_frame_start", 32'(bus.Frame_Start_Sig), 1);
        pin_win = pin;
        send_line(0, 1, H_TOT);
        for (int ln = 1; ln < V_TOT; ln++) send_line(ln, 0, H_TOT);
        pin_win = 0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ready"}, 32'(bus.Ready_Sig), 0);
        chk({tag, "_col"}, 32'(bus.Column_Addr_Sig), 0);
        chk({tag, "_row"}, 32'(bus.Row_Addr_Sig), 0);
        chk({tag, "_locked"}, 32'(bus.Locked_Sig), 0);
        chk({tag, "_h_total"}, 32'(bus.H_Total_Sig), 0);
        chk({tag, "_v_total"}, 32'(bus.V_Total_Sig), 0);
        chk({tag, "_frame_start"}, 32'(bus.Frame_Start_Sig), 0);
`ifdef VGA_RX_ERRCNT_EN
        chk({tag, "_err"}, 32'(bus.Err_Count_Sig), 0);
`endif
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        rst = 1;
        bus.Pixel_En = 0; bus.HSYNC_Sig = 1; bus.VSYNC_Sig = 1;
        repeat (4) @(negedge clk);
        chk_all_zero("por");
        rst = 0;

        lock_sequence(1);

        // One short line inside a locked frame.
        g = $urandom_range(4, 15);
        for (int ln = 0; ln < V_TOT; ln++) begin
            if (ln == g) begin
                send_line(ln, 0, H_TOT - 1);
            end else if (ln == g + 1) begin
                send_line(ln, 0, 1);
                chk("glitch_locked", 32'(bus.Locked_Sig), 0);
                chk("glitch_ready", 32'(bus.Ready_Sig), 0);
                chk("glitch_h_total", 32'(bus.H_Total_Sig), H_TOT - 1);
`ifdef VGA_RX_ERRCNT_EN
                chk("glitch_err", 32'(bus.Err_Count_Sig), 1);
`endif
                send_line(ln, 1, H_TOT);
            end else begin
                send_line(ln, 0, H_TOT);
            end
        end
        repeat (3) send_frame();
        chk("relock_pending", 32'(bus.Locked_Sig), 0);
        send_line(0, 0, 1);
        chk("relocked", 32'(bus.Locked_Sig), 1);
        send_line(0, 1, H_TOT);
        for (int ln = 1; ln < V_TOT; ln++) send_line(ln, 0, H_TOT);

        // Reset in the middle of an active line.
        for (int ln = 0; ln < 5; ln++) send_line(ln, 0, H_TOT);
        send_line(5, 0, 21);
        chk("pre_rst_ready", 32'(bus.Ready_Sig), 1);
        chk("pre_rst_col", 32'(bus.Column_Addr_Sig), 12);
        chk("pre_rst_row", 32'(bus.Row_Addr_Sig), 2);
        @(negedge clk);
        bus.Pixel_En = 0;
        rst = 1;
        #1;
        chk_all_zero("mid_rst");
        repeat (3) @(negedge clk);
        rst = 0;

        lock_sequence(0);

        // HSYNC stuck high while locked.
        for (int ln = 0; ln < 6; ln++) send_line(ln, 0, H_TOT);
        repeat (2100) send_px(1'b1, 1'b1);
        chk("loss_locked", 32'(bus.Locked_Sig), 0);
        chk("loss_ready", 32'(bus.Ready_Sig), 0);
        chk("loss_col", 32'(bus.Column_Addr_Sig), 0);
        chk("loss_row", 32'(bus.Row_Addr_Sig), 0);
        send_frame();
        send_frame();
        chk("resume_locked", 32'(bus.Locked_Sig), 0);

        @(negedge clk);
        bus.Pixel_En = 0;
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/vga_timing_receiver.md
Name: vga_timing_receiver

Overview:
- Sink-side counterpart of the VGA sync generator. Monitors incoming HSYNC/VSYNC (active-low) on the pixel strobe and measures line and frame lengths.
- Locks onto a stable timing and regenerates Column/Row addresses plus an active-video Ready flag for downstream capture or checking logic.
- Serves as the in-system checker for the display path and as the front end of a future VGA capture path.

Parameters:
H_START, 144, first active pixel index after HSYNC falling edge
H_ACTIVE, 640, active pixels per line
V_START, 35, first active line index after VSYNC falling edge
V_ACTIVE, 480, active lines per frame
LOCK_FRAMES, 2, consecutive matching frame measurements required to lock (1..7)

Ports:
CLK  in  1  system clock
RST  in  1  asynchronous active-high reset
Pixel_En  in  1  pixel strobe; all sampling/counting only on cycles with Pixel_En=1
HSYNC_Sig  in  1  horizontal sync, active low
VSYNC_Sig  in  1  vertical sync, active low
Ready_Sig  out  1  current pixel is inside active window and receiver is locked
Column_Addr_Sig  out  11  active column, 0-based; 0 when Ready_Sig=0
Row_Addr_Sig  out  11  active row, 0-based; 0 when Ready_Sig=0
Locked_Sig  out  1  timing locked
H_Total_Sig  out  11  last measured line length in pixels
V_Total_Sig  out  11  last measured frame length in lines
Frame_Start_Sig  out  1  one-CLK pulse on the Pixel_En cycle a VSYNC falling edge is detected

Behaviour:
- Reset (RST=1, async): all registers 0; state SEARCH; all outputs 0. Reset mid-frame takes effect immediately, with no wait for the frame boundary.
- hs_q: HSYNC_Sig registered on Pixel_En. hs_fall = Pixel_En & hs_q & ~HSYNC_Sig.
- h_cnt (11b):
  - On hs_fall: h_cnt<=0, H_Total_Sig<=h_cnt+1.
  - Otherwise on Pixel_En: h_cnt+1, saturating at 2047.
- vs_line: VSYNC_Sig registered only on hs_fall. vs_fall = hs_fall & vs_line & ~VSYNC_Sig.
- v_cnt (11b):
  - On vs_fall: v_cnt<=0, V_Total_Sig<=v_cnt+1, Frame_Start_Sig=1 for that CLK.
  - Otherwise on hs_fall: v_cnt+1, saturating at 2047.
- Lock FSM:
  - SEARCH: Locked=0, match=0, ref_valid=0. On vs_fall -> MEASURE.
  - MEASURE: on each vs_fall:
    - If !ref_valid: store ref_h=H_Total (line just closed), ref_v=v_cnt+1; set ref_valid.
    - Else if both equal the refs: match+1.
    - Else: match=0 and the refs are reloaded.
    - When match reaches LOCK_FRAMES -> LOCKED (Locked_Sig=1 from the next CLK).
  - LOCKED: on hs_fall, any line length != ref_h -> SEARCH. On vs_fall, frame length != ref_v -> SEARCH.
  - Any state: h_cnt or v_cnt reaching 2047 (lost sync) -> SEARCH.
  - Simultaneous line mismatch and vs_fall in LOCKED: SEARCH wins. The vs_fall is not reused to enter MEASURE; the next vs_fall does that.
  - First line after reset (partial) is measured but never compared.
- Active window: active = LOCKED & H_START<=h_cnt<H_START+H_ACTIVE & V_START<=v_cnt<V_START+V_ACTIVE.
  - Ready_Sig is combinational from registered state/counters.
  - Column = h_cnt-H_START and Row = v_cnt-V_START when active, else 0. All arithmetic is 11-bit unsigned.
- Latency: the first pixel after an HSYNC falling edge is h_cnt=0; addresses reflect the pixel sampled on the same Pixel_En edge that updates h_cnt.

Optional Feature:
VGA_RX_ERRCNT_EN:
- Defined: adds output Err_Count_Sig [7:0].
  - Increments (saturating at 255) on every LOCKED->SEARCH transition.
  - Reset to 0 only by RST.
- Undefined: port and counter absent; all other behaviour is identical.

Test Plan:
- Common bench source: ideal, Pixel_En every 4th CLK, 800 px/line, HSYNC low px 0-95, 525 lines, VSYNC low lines 0-1.
- Reset: assert RST mid-line -> same CLK all outputs 0; after release Locked_Sig=0 until sync seen.
- Lock (LOCK_FRAMES=2): -> Locked_Sig rises 1 CLK after the 4th VSYNC falling edge; H_Total_Sig=800, V_Total_Sig=525; one Frame_Start_Sig pulse per frame.
- Window (locked):
  - h_cnt=143 -> Ready=0.
  - h_cnt=144, v_cnt=35 -> Ready=1, Column=0, Row=0.
  - h_cnt=783, v_cnt=514 -> Column=639, Row=479.
  - h_cnt=784 -> Ready=0, Column=0.
- Line glitch: shorten one line to 799 px while locked -> at its hs_fall Locked_Sig=0, Ready_Sig=0, H_Total_Sig=799, Err_Count_Sig=1 (with VGA_RX_ERRCNT_EN). Relocks after 4 more clean VSYNC falling edges.
- Sync loss: hold HSYNC_Sig high while locked -> after h_cnt saturates at 2047, state SEARCH, Locked_Sig=0; no address output while HSYNC stays high.
